dcf_encoder: RTL and testbench



---
 rtl/dcf_pkg.sv | 24 ++
 rtl/dcf_frame_builder.sv | 31 +++
 rtl/dcf_encoder.sv | 100 ++++++++++
 tb/tb_dcf_encoder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcf_pkg.sv
// DCF77 encoder shared definitions: frame layout, default tick timing, time fields.
package dcf_pkg;

  localparam int unsigned DCF_FRAME_BITS    = 59;
  localparam int unsigned DCF_BIT_START     = 20;
  localparam int unsigned DCF_BIT_P1        = 28;
  localparam int unsigned DCF_BIT_P2        = 35;
  localparam int unsigned DCF_BIT_P3        = 58;

  localparam int unsigned DCF_TICKS_PER_SEC = 1024;
  localparam int unsigned DCF_T0_TICKS      = 102;
  localparam int unsigned DCF_T1_TICKS      = 205;

  // BCD time/date announced in the next frame; weekday is plain binary 1-7.
  typedef struct packed {
    logic [7:0] year;
    logic [4:0] month;
    logic [2:0] weekday;
    logic [5:0] day;
    logic [5:0] hour;
    logic [6:0] minute;
  } dcf_time_t;

endpackage

// File: rtl/dcf_frame_builder.sv
// Combinational packing of time fields into a 59-bit DCF77 frame with even parity.
// Optional DCF_ENC_FAULT_INJECT_EN adds inject_parity_err, which inverts P3.
module dcf_frame_builder
  import dcf_pkg::*;
(
  input  dcf_time_t                 tm,
  input  logic                      cest,
`ifdef DCF_ENC_FAULT_INJECT_EN
  input  logic                      inject_parity_err,
`endif
  output logic [DCF_FRAME_BITS-1:0] frame
);

  logic p1;
  logic p2;
  logic p3;

  // Even parity per group, then concatenate fields MSB (bit 58) down to bit 0.
  always_comb begin
    p1 = ^tm.minute;
    p2 = ^tm.hour;
`ifdef DCF_ENC_FAULT_INJECT_EN
    p3 = (^{tm.year, tm.month, tm.weekday, tm.day}) ^ inject_parity_err;
`else
    p3 = ^{tm.year, tm.month, tm.weekday, tm.day};
`endif
    frame = {p3, tm.year, tm.month, tm.weekday, tm.day, p2, tm.hour, p1,
             tm.minute, 1'b1, 1'b0, ~cest, cest, 17'b0};
  end

endmodule

// File: rtl/dcf_encoder.sv
// DCF77 time-code transmitter timed by a 1024 Hz clock enable.
// Optional DCF_ENC_FAULT_INJECT_EN adds inject_parity_err (inverts P3 of one frame).
module dcf_encoder
  import dcf_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DCF_TICKS_PER_SEC,
  parameter int unsigned T0_TICKS      = DCF_T0_TICKS,
  parameter int unsigned T1_TICKS      = DCF_T1_TICKS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       ce_1024Hz,
  input  logic       cest,
  input  logic [6:0] minute,
  input  logic [5:0] hour,
  input  logic [5:0] day,
  input  logic [2:0] weekday,
  input  logic [4:0] month,
  input  logic [7:0] year,
`ifdef DCF_ENC_FAULT_INJECT_EN
  input  logic       inject_parity_err,
`endif
  output logic       dcf_out,
  output logic [5:0] second_idx,
  output logic       minute_start
);

  localparam logic [9:0] TICK_MAX = 10'(TICKS_PER_SEC - 1);
  localparam logic [9:0] LEN0     = 10'(T0_TICKS);
  localparam logic [9:0] LEN1     = 10'(T1_TICKS);
  localparam logic [5:0] LAST_SEC = 6'd59;

  dcf_time_t                 tm;
  logic [DCF_FRAME_BITS-1:0] built;
  logic [DCF_FRAME_BITS-1:0] frame;
  logic [DCF_FRAME_BITS-1:0] frame_nxt;
  logic [63:0]               frame_ext;
  logic [9:0]                tick_cnt;
  logic [9:0]                tick_nxt;
  logic [9:0]                pulse_len;
  logic [5:0]                sec_nxt;
  logic                      wrap;
  logic                      load;
  logic                      pulse;

  assign tm = '{year: year, month: month, weekday: weekday, day: day,
                hour: hour, minute: minute};

  dcf_frame_builder u_builder (
    .tm                (tm),
    .cest              (cest),
`ifdef DCF_ENC_FAULT_INJECT_EN
    .inject_parity_err (inject_parity_err),
`endif
    .frame             (built)
  );

  // Next-state of the counters and frame; dcf_out is derived from these so the
  // output register reflects the new second in the same cycle the counters wrap.
  always_comb begin
    wrap      = (tick_cnt == TICK_MAX);
    tick_nxt  = wrap ? '0 : tick_cnt + 10'd1;
    sec_nxt   = second_idx;
    if (wrap) begin
      sec_nxt = (second_idx == LAST_SEC) ? '0 : second_idx + 6'd1;
    end
    load      = wrap && (second_idx == LAST_SEC);
    frame_nxt = load ? built : frame;
    frame_ext = {5'b0, frame_nxt};
    pulse_len = frame_ext[sec_nxt] ? LEN1 : LEN0;
    pulse     = (sec_nxt != LAST_SEC) && (tick_nxt < pulse_len);
  end

  // Tick/second counters, frame register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt     <= '0;
      second_idx   <= LAST_SEC;
      frame        <= '0;
      dcf_out      <= 1'b1;
      minute_start <= 1'b0;
    end else if (!enable) begin
      tick_cnt     <= '0;
      second_idx   <= LAST_SEC;
      frame        <= '0;
      dcf_out      <= 1'b1;
      minute_start <= 1'b0;
    end else if (ce_1024Hz) begin
      tick_cnt     <= tick_nxt;
      second_idx   <= sec_nxt;
      frame        <= frame_nxt;
      dcf_out      <= ~pulse;
      minute_start <= load;
    end else begin
      minute_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dcf_encoder.sv
// Directed self-checking bench for dcf_encoder (shortened second for run time).
module tb_dcf_encoder;
  import dcf_pkg::*;

  localparam int TPS = 256;
  localparam int T0  = 102;
  localparam int T1  = 205;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       ce_1024Hz;
  logic       cest;
  logic [6:0] minute;
  logic [5:0] hour;
  logic [5:0] day;
  logic [2:0] weekday;
  logic [4:0] month;
  logic [7:0] year;
`ifdef DCF_ENC_FAULT_INJECT_EN
  logic       inject_parity_err;
`endif
  logic       dcf_out;
  logic [5:0] second_idx;
  logic       minute_start;

  int errors = 0;
  int checks = 0;
  int lows[60];
  int secs[60];
  logic [58:0] frame_a;
  logic [58:0] frame_b;

  always #5 clk = ~clk;

  dcf_encoder #(
    .TICKS_PER_SEC (TPS),
    .T0_TICKS      (T0),
    .T1_TICKS      (T1)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .ce_1024Hz         (ce_1024Hz),
    .cest              (cest),
    .minute            (minute),
    .hour              (hour),
    .day               (day),
    .weekday           (weekday),
    .month             (month),
    .year              (year),
`ifdef DCF_ENC_FAULT_INJECT_EN
    .inject_parity_err (inject_parity_err),
`endif
    .dcf_out           (dcf_out),
    .second_idx        (second_idx),
    .minute_start      (minute_start)
  );

  function automatic logic [58:0] ref_frame(input logic c, input logic [6:0] mi,
      input logic [5:0] hr, input logic [5:0] dy, input logic [2:0] wd,
      input logic [4:0] mo, input logic [7:0] yr, input logic inj);
    logic [58:0] f;
    f = '0;
    f[17] = c;
    f[18] = ~c;
    f[20] = 1'b1;
    for (int i = 0; i < 7; i++) f[21+i] = mi[i];
    f[28] = ^mi;
    for (int i = 0; i < 6; i++) f[29+i] = hr[i];
    f[35] = ^hr;
    for (int i = 0; i < 6; i++) f[36+i] = dy[i];
    for (int i = 0; i < 3; i++) f[42+i] = wd[i];
    for (int i = 0; i < 5; i++) f[45+i] = mo[i];
    for (int i = 0; i < 8; i++) f[50+i] = yr[i];
    f[58] = (^f[57:36]) ^ inj;
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic set_inputs_a();
    cest = 1'b0; minute = 7'h37; hour = 6'h21; day = 6'h15;
    weekday = 3'd3; month = 5'h07; year = 8'h24;
  endtask

  task automatic set_inputs_b();
    cest = 1'b1; minute = 7'h59; hour = 6'h23; day = 6'h31;
    weekday = 3'd7; month = 5'h12; year = 8'h99;
  endtask

  // Starts at the sample just after the wrap into second 0; ends at the next one.
  task automatic run_minute(input bit change_at_30);
    for (int s = 0; s < 60; s++) begin
      secs[s] = int'(second_idx);
      lows[s] = 0;
      if (change_at_30 && s == 30) set_inputs_b();
      for (int j = 0; j < TPS; j++) begin
        if (dcf_out === 1'b0) lows[s]++;
        step();
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; ce_1024Hz = 1'b0;
`ifdef DCF_ENC_FAULT_INJECT_EN
    inject_parity_err = 1'b0;
`endif
    set_inputs_a();
    step_n(3);
    checks++;
    if (dcf_out !== 1'b1 || second_idx !== 6'd59 || minute_start !== 1'b0) begin
      errors++;
      $display("FAIL reset: dcf_out=%b sec=%0d ms=%b, expected 1 59 0", dcf_out, second_idx, minute_start);
    end
    reset_n = 1'b1; ce_1024Hz = 1'b1;
    step_n(300);
    checks++;
    if (dcf_out !== 1'b1 || second_idx !== 6'd59 || minute_start !== 1'b0) begin
      errors++;
      $display("FAIL disabled_idle: dcf_out=%b sec=%0d ms=%b, expected 1 59 0", dcf_out, second_idx, minute_start);
    end
  endtask

  task automatic test_first_edge();
    int bad;
    bad = 0;
    enable = 1'b1;
    for (int i = 0; i < TPS - 1; i++) begin
      step();
      if (dcf_out !== 1'b1 || minute_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || second_idx !== 6'd59) begin
      errors++;
      $display("FAIL first_gap: low_cycles=%0d sec=%0d, expected 0 59", bad, second_idx);
    end
    step();
    checks++;
    if (dcf_out !== 1'b0 || minute_start !== 1'b1 || second_idx !== 6'd0) begin
      errors++;
      $display("FAIL first_edge: dcf_out=%b ms=%b sec=%0d, expected 0 1 0", dcf_out, minute_start, second_idx);
    end
  endtask

  task automatic test_frame_a();
    int exp;
    run_minute(1'b1);
    for (int s = 0; s < 60; s++) begin
      exp = (s == 59) ? 0 : (frame_a[s] ? T1 : T0);
      checks++;
      if (lows[s] !== exp || secs[s] !== s) begin
        errors++;
        $display("FAIL frame_a sec%0d: low=%0d idx=%0d, expected low=%0d idx=%0d", s, lows[s], secs[s], exp, s);
      end
    end
    checks++;
    if (lows[DCF_BIT_START] !== 205 || lows[18] !== 205 || lows[17] !== 102 ||
        lows[DCF_BIT_P1] !== 205 || lows[DCF_BIT_P2] !== 102 || lows[DCF_BIT_P3] !== 102) begin
      errors++;
      $display("FAIL frame_a_fields: b20=%0d b18=%0d b17=%0d p1=%0d p2=%0d p3=%0d, expected 205 205 102 205 102 102",
               lows[20], lows[18], lows[17], lows[28], lows[35], lows[58]);
    end
  endtask

  task automatic test_midminute_change();
    int exp;
    checks++;
    if (minute_start !== 1'b1 || second_idx !== 6'd0) begin
      errors++;
      $display("FAIL minute2_start: ms=%b sec=%0d, expected 1 0", minute_start, second_idx);
    end
    run_minute(1'b0);
    for (int s = 0; s < 60; s++) begin
      exp = (s == 59) ? 0 : (frame_b[s] ? T1 : T0);
      checks++;
      if (lows[s] !== exp) begin
        errors++;
        $display("FAIL frame_b sec%0d: low=%0d, expected %0d", s, lows[s], exp);
      end
    end
    checks++;
    if (lows[17] !== 205 || lows[18] !== 102 || lows[28] !== 102 ||
        lows[35] !== 205 || lows[58] !== 102) begin
      errors++;
      $display("FAIL frame_b_fields: b17=%0d b18=%0d p1=%0d p2=%0d p3=%0d, expected 205 102 102 205 102",
               lows[17], lows[18], lows[28], lows[35], lows[58]);
    end
  endtask

  task automatic test_enable();
    int bad;
    bad = 0;
    step_n(20 * TPS);
    checks++;
    if (dcf_out !== 1'b0 || second_idx !== 6'd20) begin
      errors++;
      $display("FAIL bit20_start: dcf_out=%b sec=%0d, expected 0 20", dcf_out, second_idx);
    end
    ce_1024Hz = 1'b0;
    step_n(40);
    checks++;
    if (dcf_out !== 1'b0 || second_idx !== 6'd20 || minute_start !== 1'b0) begin
      errors++;
      $display("FAIL ce_hold: dcf_out=%b sec=%0d ms=%b, expected 0 20 0", dcf_out, second_idx, minute_start);
    end
    ce_1024Hz = 1'b1;
    step_n(10);
    enable = 1'b0;
    step();
    checks++;
    if (dcf_out !== 1'b1 || second_idx !== 6'd59 || minute_start !== 1'b0) begin
      errors++;
      $display("FAIL disable: dcf_out=%b sec=%0d ms=%b, expected 1 59 0", dcf_out, second_idx, minute_start);
    end
    step_n(5);
    enable = 1'b1;
    for (int i = 0; i < TPS - 1; i++) begin
      step();
      if (dcf_out !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || second_idx !== 6'd59) begin
      errors++;
      $display("FAIL reenable_gap: low_cycles=%0d sec=%0d, expected 0 59", bad, second_idx);
    end
    step();
    checks++;
    if (dcf_out !== 1'b0 || minute_start !== 1'b1 || second_idx !== 6'd0) begin
      errors++;
      $display("FAIL reenable_edge: dcf_out=%b ms=%b sec=%0d, expected 0 1 0", dcf_out, minute_start, second_idx);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    bad = 0;
    step_n(5);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dcf_out !== 1'b1 || second_idx !== 6'd59) begin
      errors++;
      $display("FAIL async_reset: dcf_out=%b sec=%0d, expected 1 59", dcf_out, second_idx);
    end
    step_n(2);
    reset_n = 1'b1;
    for (int i = 0; i < TPS - 1; i++) begin
      step();
      if (dcf_out !== 1'b1) bad++;
    end
    step();
    checks++;
    if (bad != 0 || dcf_out !== 1'b0 || minute_start !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_edge: low_cycles=%0d dcf_out=%b ms=%b, expected 0 0 1", bad, dcf_out, minute_start);
    end
  endtask

`ifdef DCF_ENC_FAULT_INJECT_EN
  task automatic test_fault_inject();
    logic [58:0] frame_bad;
    int exp;
    frame_bad = ref_frame(1'b1, 7'h59, 6'h23, 6'h31, 3'd7, 5'h12, 8'h99, 1'b1);
    inject_parity_err = 1'b1;
    run_minute(1'b0);
    inject_parity_err = 1'b0;
    checks++;
    if (lows[58] !== 102) begin
      errors++;
      $display("FAIL inject_before: p3=%0d, expected 102", lows[58]);
    end
    run_minute(1'b0);
    for (int s = 0; s < 60; s++) begin
      exp = (s == 59) ? 0 : (frame_bad[s] ? T1 : T0);
      checks++;
      if (lows[s] !== exp) begin
        errors++;
        $display("FAIL inject_frame sec%0d: low=%0d, expected %0d", s, lows[s], exp);
      end
    end
    checks++;
    if (lows[58] !== 205) begin
      errors++;
      $display("FAIL inject_p3: low=%0d, expected 205", lows[58]);
    end
    run_minute(1'b0);
    checks++;
    if (lows[58] !== 102 || lows[28] !== 102 || lows[35] !== 205) begin
      errors++;
      $display("FAIL inject_after: p3=%0d p1=%0d p2=%0d, expected 102 102 205", lows[58], lows[28], lows[35]);
    end
  endtask
`endif

  initial begin
    frame_a = ref_frame(1'b0, 7'h37, 6'h21, 6'h15, 3'd3, 5'h07, 8'h24, 1'b0);
    frame_b = ref_frame(1'b1, 7'h59, 6'h23, 6'h31, 3'd7, 5'h12, 8'h99, 1'b0);
    test_reset();
    test_first_edge();
    test_frame_a();
    test_midminute_change();
    test_enable();
    test_async_reset();
`ifdef DCF_ENC_FAULT_INJECT_EN
    test_fault_inject();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
